// File: rtl/addr_burst_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : addr_burst_sequencer
//  Purpose  : Pops base addresses from an address FIFO and issues each one,
//             optionally followed by consec_count incrementing addresses, on
//             a valid/ready address stream. Tracks progress with an issued
//             address counter, a sticky underrun flag and a done pulse.
//  Ports    : clk, reset (sync, active-high)
//             run_program / end_program / abort_program   - program control
//             freeze_addr_fifo                            - hold FIFO fetches
//             send_consec_addr, consec_count              - burst extension
//             addr_fifo_threshold, words_in_addr_fifo     - prime level
//             addr_fifo_dout, addr_fifo_empty, addr_fifo_rd - FIFO read side
//             vec_addr, vec_addr_valid, vec_addr_ready    - address stream
//             seq_active, seq_done, seq_underrun, addr_issued_cnt - status
//  Config   : ADDR_SEQ_PRIME_EN defined   -> PRIME state waits for the FIFO
//                                            to reach addr_fifo_threshold.
//             ADDR_SEQ_PRIME_EN undefined -> run edge goes straight to FETCH.
//  Revision : 1.0 - initial release
// ============================================================================
module addr_burst_sequencer #(
  parameter int ADDR_W      = 32,
  parameter int ISSUE_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run_program,
  input  logic                   end_program,
  input  logic                   abort_program,
  input  logic                   freeze_addr_fifo,
  input  logic                   send_consec_addr,
  input  logic [7:0]             consec_count,
  input  logic [15:0]            addr_fifo_threshold,
  input  logic [15:0]            words_in_addr_fifo,
  input  logic [ADDR_W-1:0]      addr_fifo_dout,
  input  logic                   addr_fifo_empty,
  output logic                   addr_fifo_rd,
  output logic [ADDR_W-1:0]      vec_addr,
  output logic                   vec_addr_valid,
  input  logic                   vec_addr_ready,
  output logic                   seq_active,
  output logic                   seq_done,
  output logic                   seq_underrun,
  output logic [ISSUE_CNT_W-1:0] addr_issued_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRIME = 3'd1,
    S_FETCH = 3'd2,
    S_LOAD  = 3'd3,
    S_ISSUE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t     state;
  logic       run_q;
  logic [7:0] burst_rem;

  logic run_edge;
  logic accept;
  logic pop;

  assign run_edge = run_program & ~run_q;
  assign accept   = vec_addr_valid & vec_addr_ready;

  // The pop strobe is decoded from the FETCH state rather than registered so
  // the FIFO's one-cycle read latency lines up with LOAD; an abort or reset
  // in the same cycle suppresses it so no word is lost.
  assign pop          = (state == S_FETCH) & ~freeze_addr_fifo & ~addr_fifo_empty;
  assign addr_fifo_rd = pop & ~abort_program & ~reset;

`ifndef ADDR_SEQ_PRIME_EN
  // Prime-level inputs have no consumer without the PRIME state.
  logic unused_prime_inputs;
  assign unused_prime_inputs = ^{addr_fifo_threshold, words_in_addr_fifo};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      run_q           <= 1'b0;
      burst_rem       <= 8'd0;
      vec_addr        <= '0;
      vec_addr_valid  <= 1'b0;
      seq_active      <= 1'b0;
      seq_done        <= 1'b0;
      seq_underrun    <= 1'b0;
      addr_issued_cnt <= '0;
    end else begin
      run_q    <= run_program;
      seq_done <= 1'b0;

      if (abort_program && (state != S_IDLE)) begin
        // Abort beats every other event, including a handshake in flight.
        state          <= S_IDLE;
        vec_addr_valid <= 1'b0;
        seq_active     <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (run_edge) begin
              seq_underrun    <= 1'b0;
              addr_issued_cnt <= '0;
              seq_active      <= 1'b1;
`ifdef ADDR_SEQ_PRIME_EN
              state           <= S_PRIME;
`else
              state           <= S_FETCH;
`endif
            end
          end

`ifdef ADDR_SEQ_PRIME_EN
          S_PRIME: begin
            if ((words_in_addr_fifo >= addr_fifo_threshold) || end_program) begin
              state <= S_FETCH;
            end
          end
`endif

          S_FETCH: begin
            if (!freeze_addr_fifo) begin
              if (!addr_fifo_empty) begin
                state <= S_LOAD;
              end else if (end_program) begin
                state    <= S_DONE;
                seq_done <= 1'b1;
              end else begin
                seq_underrun <= 1'b1;
              end
            end
          end

          S_LOAD: begin
            // Burst length is sampled only here; later changes to the
            // consec controls apply to the next FIFO word.
            vec_addr       <= addr_fifo_dout;
            burst_rem      <= send_consec_addr ? consec_count : 8'd0;
            vec_addr_valid <= 1'b1;
            state          <= S_ISSUE;
          end

          S_ISSUE: begin
            if (accept) begin
              if (addr_issued_cnt != '1) begin
                addr_issued_cnt <= addr_issued_cnt + ISSUE_CNT_W'(1);
              end
              if (burst_rem == 8'd0) begin
                vec_addr_valid <= 1'b0;
                state          <= S_FETCH;
              end else begin
                // Natural wrap at 2^ADDR_W.
                vec_addr  <= vec_addr + ADDR_W'(1);
                burst_rem <= burst_rem - 8'd1;
              end
            end
          end

          S_DONE: begin
            seq_active <= 1'b0;
            state      <= S_IDLE;
          end

          default: begin
            vec_addr_valid <= 1'b0;
            seq_active     <= 1'b0;
            state          <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire
